// File: rtl/jcpu_pkg.sv
// Shared definitions for the J-CPU control path.
// Holds the instruction opcode constants, the default halt encoding, the ALU
// operation codes, the flag bit positions and the decoded instruction class
// record used between the decoder and the control sequencer.
package jcpu_pkg;

  // Upper nibble of the non-ALU instructions (bit 7 clear).
  localparam logic [3:0] OP_LD    = 4'b0000;
  localparam logic [3:0] OP_ST    = 4'b0001;
  localparam logic [3:0] OP_DATA  = 4'b0010;
  localparam logic [3:0] OP_JMPR  = 4'b0011;
  localparam logic [3:0] OP_JMP   = 4'b0100;
  localparam logic [3:0] OP_JCOND = 4'b0101;

  // CLF is a full-byte encoding inside the 0110 group.
  localparam logic [7:0] OP_CLF = 8'h60;

  // Default full-byte encoding that stops the stepper.
  localparam logic [7:0] HALT_OP_DEF = 8'h61;

  // ALU operation codes carried in ir[6:4] of an ALU instruction.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SHR = 3'b001,
    ALU_SHL = 3'b010,
    ALU_NOT = 3'b011,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101,
    ALU_XOR = 3'b110,
    ALU_CMP = 3'b111
  } alu_op_e;

  // Bit positions inside the 4-bit flags word {carry, a_larger, equal, zero}.
  localparam int FLAG_C = 3;
  localparam int FLAG_A = 2;
  localparam int FLAG_E = 1;
  localparam int FLAG_Z = 0;

  // One-hot instruction class. All fields clear means the encoding has no
  // work to do in steps 4-6 (unused 0110/0111 encodings).
  typedef struct packed {
    logic alu;
    logic ld;
    logic st;
    logic data;
    logic jmpr;
    logic jmp;
    logic jcond;
    logic clf;
    logic halt;
  } instr_class_t;

endpackage

// File: rtl/jinstr_decode.sv
// Combinational instruction decoder.
// Turns the latched instruction byte into a one-hot instruction class plus
// the register selectors and ALU operation field.
// Ports:
//   ir   in   WIDTH  latched instruction register
//   cls  out  class  one-hot instruction class (all zero = no-op encoding)
//   op   out  3      ALU operation field
//   ra   out  2      register A selector
//   rb   out  2      register B selector
module jinstr_decode
  import jcpu_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] HALT_OP = WIDTH'(HALT_OP_DEF)
) (
  input  logic [WIDTH-1:0] ir,
  output instr_class_t     cls,
  output logic [2:0]       op,
  output logic [1:0]       ra,
  output logic [1:0]       rb
);

  // Bit 7 alone marks an ALU instruction. Among the rest, the halt and CLF
  // full-byte encodings are matched before the upper-nibble opcode so that
  // they win over the generic 0110/0111 "do nothing" group.
  always_comb begin
    cls = '0;
    op  = ir[WIDTH-2 -: 3];
    ra  = ir[3:2];
    rb  = ir[1:0];
    if (ir[WIDTH-1]) begin
      cls.alu = 1'b1;
    end else if (ir == HALT_OP) begin
      cls.halt = 1'b1;
    end else if (ir == WIDTH'(OP_CLF)) begin
      cls.clf = 1'b1;
    end else begin
      case (ir[WIDTH-1 -: 4])
        OP_LD:    cls.ld    = 1'b1;
        OP_ST:    cls.st    = 1'b1;
        OP_DATA:  cls.data  = 1'b1;
        OP_JMPR:  cls.jmpr  = 1'b1;
        OP_JMP:   cls.jmp   = 1'b1;
        OP_JCOND: cls.jcond = 1'b1;
        default:  cls       = '0;
      endcase
    end
  end

endmodule

// File: rtl/jcontrol_seq.sv
// Control sequencer for the J-CPU.
// Consumes the clock phases and the one-hot stepper, and produces the
// datapath enable/set strobes, the ALU operation, flag capture and the halt
// request. Keeps its own copies of the instruction and flags registers.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   clke, clks            enable phase / set phase from the clock generator
//   bos[0:5]              one-hot stepper, bos[0] is step 1
//   bus                   system bus, sampled for the instruction capture
//   alu_flags             {carry, a_larger, equal, zero} from the ALU
//   bus1                  forces constant 1 onto ALU input B
//   ena_* / set_*         datapath strobes (ena on clke, set on clks)
//   ena_reg, set_reg      one-hot general register enable/set, [0] is R0
//   alu_op                ALU operation, held for the whole step
//   set_flags, flags      flag register load strobe and latched flags
//   halt                  sticky request to the stepper halt input
module jcontrol_seq
  import jcpu_pkg::*;
#(
  parameter int               NREG    = 4,
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] HALT_OP = WIDTH'(HALT_OP_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clke,
  input  logic             clks,
  input  logic [0:5]       bos,
  input  logic [WIDTH-1:0] bus,
  input  logic [3:0]       alu_flags,
  output logic             bus1,
  output logic             ena_iar,
  output logic             set_iar,
  output logic             ena_ram,
  output logic             set_ram,
  output logic             set_mar,
  output logic             set_ir,
  output logic             ena_acc,
  output logic             set_acc,
  output logic             set_tmp,
  output logic [0:NREG-1]  ena_reg,
  output logic [0:NREG-1]  set_reg,
  output logic [2:0]       alu_op,
  output logic             set_flags,
  output logic [3:0]       flags,
  output logic             halt
);

  logic [WIDTH-1:0] ir_q;
  instr_class_t     cls;
  logic [2:0]       op;
  logic [1:0]       ra;
  logic [1:0]       rb;
  logic             bos_valid;
  logic [0:5]       step;
  logic             jcond_taken;

  jinstr_decode #(
    .WIDTH   (WIDTH),
    .HALT_OP (HALT_OP)
  ) u_decode (
    .ir  (ir_q),
    .cls (cls),
    .op  (op),
    .ra  (ra),
    .rb  (rb)
  );

  // A step is only acted on when the stepper is exactly one-hot and the
  // sequencer is neither in reset nor halted; otherwise every step line is
  // treated as idle so no strobe can fire and no state can load.
  assign bos_valid   = (bos != '0) && ((bos & (bos - 6'd1)) == '0);
  assign step        = (!reset && !halt && bos_valid) ? bos : '0;
  assign jcond_taken = |({ra, rb} & flags);

  // Instruction, flags and halt registers. The instruction register loads
  // from the bus on the step-2 set strobe, the flags load on the flag set
  // strobe (CLF loads zero instead of the ALU flags), and halt latches on
  // the step-4 set phase of the halt instruction and stays until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q  <= '0;
      flags <= '0;
      halt  <= 1'b0;
    end else begin
      if (set_ir) begin
        ir_q <= bus;
      end
      if (set_flags) begin
        flags <= cls.clf ? 4'b0000 : alu_flags;
      end
      if (step[3] && clks && cls.halt) begin
        halt <= 1'b1;
      end
    end
  end

  // Per-step strobe generation. Enables follow clke, sets follow clks,
  // while bus1 and alu_op are held for the whole step. Steps 1-3 are the
  // shared fetch; steps 4-6 depend on the decoded class. Each branch drives
  // at most one bus enable so the bus always has a single driver.
  always_comb begin
    bus1      = 1'b0;
    ena_iar   = 1'b0;
    set_iar   = 1'b0;
    ena_ram   = 1'b0;
    set_ram   = 1'b0;
    set_mar   = 1'b0;
    set_ir    = 1'b0;
    ena_acc   = 1'b0;
    set_acc   = 1'b0;
    set_tmp   = 1'b0;
    ena_reg   = '0;
    set_reg   = '0;
    alu_op    = ALU_ADD;
    set_flags = 1'b0;

    if (step[0]) begin
      bus1    = 1'b1;
      ena_iar = clke;
      set_mar = clks;
      set_acc = clks;
      alu_op  = ALU_ADD;
    end

    if (step[1]) begin
      ena_ram = clke;
      set_ir  = clks;
    end

    if (step[2]) begin
      ena_acc = clke;
      set_iar = clks;
    end

    if (step[3]) begin
      if (cls.alu) begin
        ena_reg[rb] = clke;
        set_tmp     = clks;
      end else if (cls.ld || cls.st) begin
        ena_reg[ra] = clke;
        set_mar     = clks;
      end else if (cls.data || cls.jcond) begin
        bus1    = 1'b1;
        ena_iar = clke;
        set_mar = clks;
        set_acc = clks;
      end else if (cls.jmpr) begin
        ena_reg[rb] = clke;
        set_iar     = clks;
      end else if (cls.jmp) begin
        ena_iar = clke;
        set_mar = clks;
      end else if (cls.clf) begin
        bus1      = 1'b1;
        set_flags = clks;
      end
    end

    if (step[4]) begin
      if (cls.alu) begin
        ena_reg[ra] = clke;
        alu_op      = op;
        set_acc     = clks;
        set_flags   = clks;
      end else if (cls.ld || cls.data) begin
        ena_ram     = clke;
        set_reg[rb] = clks;
      end else if (cls.st) begin
        ena_reg[rb] = clke;
        set_ram     = clks;
      end else if (cls.jmp) begin
        ena_ram = clke;
        set_iar = clks;
      end else if (cls.jcond) begin
        ena_acc = clke;
        set_iar = clks;
      end
    end

    // CMP only updates the flags, so it leaves the register file alone and
    // a conditional jump that is not taken simply falls through.
    if (step[5]) begin
      if (cls.alu && (op != ALU_CMP)) begin
        ena_acc     = clke;
        set_reg[rb] = clks;
      end else if (cls.data) begin
        ena_acc = clke;
        set_iar = clks;
      end else if (cls.jcond && jcond_taken) begin
        ena_ram = clke;
        set_iar = clks;
      end
    end
  end

endmodule
